ocp_rail_sequencer: RTL and testbench

//  Power-rail supervisor for the panel supply. Runs up to N_RAILS rails through a fixed sequence:
//   - power-up in index order, with a programmable step delay between rails;
//   - an inrush blanking window, then the per-rail OCP monitors are armed;
//   - on any OCP trip, all rails are shut down at once and the fault is latched.

---
 rtl/ocp_rail_sequencer_pkg.sv | 27 ++
 rtl/ocp_rail_sequencer_if.sv | 29 ++
 rtl/ocp_rail_sequencer_timer.sv | 31 +++
 rtl/ocp_rail_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_ocp_rail_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ocp_rail_sequencer_pkg.sv
// Shared types, widths and helpers for the OCP rail sequencer.
package ocp_rail_sequencer_pkg;

  localparam int unsigned TMR_W = 16;  // step/blank/retry timer width
  localparam int unsigned FR_W  = 3;   // FAULT_RAIL width
  localparam int unsigned RC_W  = 3;   // RETRY_CNT width

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_UP,
    S_BLANK,
    S_RUN,
    S_PWR_DOWN,
    S_FAULT
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [FR_W-1:0] lowest_set(input logic [7:0] v);
    logic [FR_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[7-i]) r = FR_W'(7 - i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ocp_rail_sequencer_if.sv
// Control/status bundle between the rail sequencer and its host/monitors.
interface ocp_rail_sequencer_if
  import ocp_rail_sequencer_pkg::*;
#(
  parameter int unsigned N_RAILS = 4
);
  logic               START;
  logic               STOP;
  logic               FAULT_CLEAR;
  logic [N_RAILS-1:0] OCP_RESULT;
  logic [N_RAILS-1:0] RAIL_EN;
  logic [N_RAILS-1:0] OCP_EN;
  logic               OCP_CLEAR;
  logic               BUSY;
  logic               PWR_GOOD;
  logic               FAULT;
  logic [FR_W-1:0]    FAULT_RAIL;
  logic [RC_W-1:0]    RETRY_CNT;

  modport slave (
    input  START, STOP, FAULT_CLEAR, OCP_RESULT,
    output RAIL_EN, OCP_EN, OCP_CLEAR, BUSY, PWR_GOOD, FAULT, FAULT_RAIL, RETRY_CNT
  );

  modport master (
    output START, STOP, FAULT_CLEAR, OCP_RESULT,
    input  RAIL_EN, OCP_EN, OCP_CLEAR, BUSY, PWR_GOOD, FAULT, FAULT_RAIL, RETRY_CNT
  );
endinterface

// File: rtl/ocp_rail_sequencer_timer.sv
// ocp_seq_timer: 16-bit loadable down-counter. Loading value D makes o_done
// high for exactly one cycle, sampled by the D-th clock edge after the load.
// A load while running restarts the interval.
module ocp_seq_timer
  import ocp_rail_sequencer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_value,
  output logic             o_done
);
  logic [TMR_W-1:0] r_cnt;
  logic             r_run;

  // Count down from value-1 to zero, then stop until the next load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_value - 1'b1;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);
endmodule

// File: rtl/ocp_rail_sequencer.sv
// Power-rail supervisor: sequenced power-up, inrush blanking, OCP arming,
// sequenced power-down and latched OCP shutdown. All outputs registered.
// Optional macro OCP_AUTO_RETRY_EN adds timed auto-retry out of FAULT.
// Delay parameters must lie in 1..65535.
module ocp_rail_sequencer
  import ocp_rail_sequencer_pkg::*;
#(
  parameter int unsigned N_RAILS   = 4,
  parameter int unsigned STEP_DLY  = 1000,
  parameter int unsigned BLANK_DLY = 5000,
  parameter int unsigned RETRY_DLY = 10000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 CLK_10MHz,
  input  logic                 RESET,
  ocp_rail_sequencer_if.slave  bus
);
  localparam logic [N_RAILS-1:0] RAIL_ONE = N_RAILS'(1);
  localparam logic [2:0]         LAST_IDX = 3'(N_RAILS - 1);

  state_t             r_state, w_state;
  logic [2:0]         r_idx, w_idx;          // highest rail currently enabled
  logic [N_RAILS-1:0] r_rail_en, w_rail_en;
  logic [N_RAILS-1:0] r_ocp_en, w_ocp_en;
  logic               r_ocp_clr, w_ocp_clr;
  logic               r_fault, w_fault;
  logic [FR_W-1:0]    r_fault_rail, w_fault_rail;
  logic               r_busy, r_pwr_good;
  logic               w_go_down, w_tmr_load, w_tmr_done;
  logic [TMR_W-1:0]   w_tmr_val;
`ifdef OCP_AUTO_RETRY_EN
  logic [RC_W-1:0]    r_retry_cnt, w_retry_cnt;
`else
  logic               w_unused_cfg;
  assign w_unused_cfg = ^{RETRY_DLY[15:0], MAX_RETRY[2:0]};
`endif

  ocp_seq_timer u_timer (
    .i_clk   (CLK_10MHz),
    .i_rst   (RESET),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // State and registered outputs; reset drops every rail immediately.
  always_ff @(posedge CLK_10MHz or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_rail_en    <= '0;
      r_ocp_en     <= '0;
      r_ocp_clr    <= 1'b1;
      r_fault      <= 1'b0;
      r_fault_rail <= '0;
      r_busy       <= 1'b0;
      r_pwr_good   <= 1'b0;
`ifdef OCP_AUTO_RETRY_EN
      r_retry_cnt  <= '0;
`endif
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_rail_en    <= w_rail_en;
      r_ocp_en     <= w_ocp_en;
      r_ocp_clr    <= w_ocp_clr;
      r_fault      <= w_fault;
      r_fault_rail <= w_fault_rail;
      r_busy       <= (w_state != S_IDLE);
      r_pwr_good   <= (w_state == S_RUN);
`ifdef OCP_AUTO_RETRY_EN
      r_retry_cnt  <= w_retry_cnt;
`endif
    end
  end

  // Next state and next outputs; priority trip > STOP > START.
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_rail_en    = r_rail_en;
    w_ocp_en     = r_ocp_en;
    w_ocp_clr    = r_ocp_clr;
    w_fault      = r_fault;
    w_fault_rail = r_fault_rail;
`ifdef OCP_AUTO_RETRY_EN
    w_retry_cnt  = r_retry_cnt;
`endif
    w_go_down    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = TMR_W'(STEP_DLY);

    unique case (r_state)
      S_IDLE: begin
        if (bus.START && !bus.STOP) begin
          w_state    = S_PWR_UP;
          w_idx      = '0;
          w_rail_en  = RAIL_ONE;
          w_tmr_load = 1'b1;
        end
      end
      S_PWR_UP: begin
        if (bus.STOP) begin
          w_go_down = 1'b1;
        end else if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state   = S_BLANK;
            w_tmr_val = TMR_W'(BLANK_DLY);
          end else begin
            w_idx     = r_idx + 3'd1;
            w_rail_en = r_rail_en | (RAIL_ONE << w_idx);
          end
        end
      end
      S_BLANK: begin
        if (bus.STOP) begin
          w_go_down = 1'b1;
        end else if (w_tmr_done) begin
          w_state   = S_RUN;
          w_ocp_en  = '1;
          w_ocp_clr = 1'b0;
        end
      end
      S_RUN: begin
        if (|bus.OCP_RESULT) begin
          // OCP_CLEAR stays low so the monitor flags remain latched.
          w_state      = S_FAULT;
          w_rail_en    = '0;
          w_ocp_en     = '0;
          w_fault      = 1'b1;
          w_fault_rail = lowest_set(8'(bus.OCP_RESULT));
`ifdef OCP_AUTO_RETRY_EN
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMR_W'(RETRY_DLY);
`endif
        end else if (bus.STOP) begin
          w_go_down = 1'b1;
        end
      end
      S_PWR_DOWN: begin
        if (w_tmr_done) begin
          w_rail_en = r_rail_en & ~(RAIL_ONE << r_idx);
          if (r_idx == '0) begin
            w_state = S_IDLE;
          end else begin
            w_idx      = r_idx - 3'd1;
            w_tmr_load = 1'b1;
          end
        end
      end
      S_FAULT: begin
        if (bus.FAULT_CLEAR) begin
          w_state      = S_IDLE;
          w_ocp_clr    = 1'b1;
          w_fault      = 1'b0;
          w_fault_rail = '0;
`ifdef OCP_AUTO_RETRY_EN
          w_retry_cnt  = '0;
        end else if (w_tmr_done && (r_retry_cnt < RC_W'(MAX_RETRY))) begin
          // Retry re-enters power-up exactly as START would; OCP_CLEAR then
          // stays high through power-up and blanking.
          w_retry_cnt = r_retry_cnt + 1'b1;
          w_ocp_clr   = 1'b1;
          w_fault     = 1'b0;
          w_state     = S_PWR_UP;
          w_idx       = '0;
          w_rail_en   = RAIL_ONE;
          w_tmr_load  = 1'b1;
`endif
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Shared STOP entry: disarm monitors, drop the highest rail at once.
    if (w_go_down) begin
      w_ocp_en  = '0;
      w_ocp_clr = 1'b1;
      w_rail_en = r_rail_en & ~(RAIL_ONE << r_idx);
`ifdef OCP_AUTO_RETRY_EN
      w_retry_cnt = '0;
`endif
      if (r_idx == '0) begin
        w_state = S_IDLE;
      end else begin
        w_state    = S_PWR_DOWN;
        w_idx      = r_idx - 3'd1;
        w_tmr_load = 1'b1;
      end
    end
  end

  assign bus.RAIL_EN    = r_rail_en;
  assign bus.OCP_EN     = r_ocp_en;
  assign bus.OCP_CLEAR  = r_ocp_clr;
  assign bus.BUSY       = r_busy;
  assign bus.PWR_GOOD   = r_pwr_good;
  assign bus.FAULT      = r_fault;
  assign bus.FAULT_RAIL = r_fault_rail;
`ifdef OCP_AUTO_RETRY_EN
  assign bus.RETRY_CNT  = r_retry_cnt;
`else
  assign bus.RETRY_CNT  = '0;
`endif
endmodule

// File: tb/tb_ocp_rail_sequencer.sv
// Bench for ocp_rail_sequencer (N_RAILS=4, STEP_DLY=4, BLANK_DLY=8;
// RETRY_DLY=10, MAX_RETRY=2 when OCP_AUTO_RETRY_EN is defined).
module tb_ocp_rail_sequencer;
  localparam int N     = 4;
  localparam int STEP  = 4;
  localparam int BLANK = 8;
  localparam int RETRY = 10;
  localparam int MAXR  = 2;
  localparam int RUN_T = N * STEP + BLANK;

  localparam int MD_OFF   = 0;
  localparam int MD_UP    = 1;
  localparam int MD_DOWN  = 2;
  localparam int MD_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ocp_rail_sequencer_if #(.N_RAILS(N)) bus ();

  ocp_rail_sequencer #(
    .N_RAILS   (N),
    .STEP_DLY  (STEP),
    .BLANK_DLY (BLANK),
    .RETRY_DLY (RETRY),
    .MAX_RETRY (MAXR)
  ) dut (
    .CLK_10MHz (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: sequence phase plus cycles elapsed in it.
  int m_mode, m_t, m_n0, m_frail, m_retry;

  function automatic int up_on(input int t);
    return (t / STEP + 1 > N) ? N : t / STEP + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= MD_OFF; m_t <= 0; m_n0 <= 0; m_frail <= 0; m_retry <= 0;
    end else begin
      case (m_mode)
        MD_OFF: if (bus.START && !bus.STOP) begin m_mode <= MD_UP; m_t <= 0; end
        MD_UP: begin
          if (m_t >= RUN_T && bus.OCP_RESULT != 0) begin
            m_mode <= MD_FAULT; m_t <= 0; m_frail <= lowest(bus.OCP_RESULT);
          end else if (bus.STOP) begin
            m_retry <= 0;
            if (up_on(m_t) == 1) m_mode <= MD_OFF;
            else begin m_mode <= MD_DOWN; m_n0 <= up_on(m_t); m_t <= 0; end
          end else if (m_t < RUN_T) m_t <= m_t + 1;
        end
        MD_DOWN: if (m_t + 1 == (m_n0 - 1) * STEP) m_mode <= MD_OFF; else m_t <= m_t + 1;
        MD_FAULT: begin
          if (bus.FAULT_CLEAR) begin
            m_mode <= MD_OFF; m_frail <= 0; m_retry <= 0;
          end
`ifdef OCP_AUTO_RETRY_EN
          else if (m_t + 1 == RETRY && m_retry < MAXR) begin
            m_mode <= MD_UP; m_t <= 0; m_retry <= m_retry + 1;
          end else if (m_t < RETRY) m_t <= m_t + 1;
`endif
        end
        default: m_mode <= MD_OFF;
      endcase
    end
  end

  // Every cycle out of reset: all outputs against the model.
  always @(negedge clk) begin : cmp
    int on;
    logic [3:0] e_rail, e_en;
    logic e_clr, e_busy, e_pg, e_fault;
    if (!rst) begin
      on = 0; e_en = '0; e_clr = 1'b1; e_busy = 1'b1; e_pg = 1'b0; e_fault = 1'b0;
      case (m_mode)
        MD_UP: begin
          on = up_on(m_t);
          if (m_t >= RUN_T) begin e_en = '1; e_clr = 1'b0; e_pg = 1'b1; end
        end
        MD_DOWN:  on = m_n0 - 1 - m_t / STEP;
        MD_FAULT: begin e_clr = 1'b0; e_fault = 1'b1; end
        default:  e_busy = 1'b0;
      endcase
      e_rail = 4'((32'd1 << on) - 1);
      chk("m_rail_en",    32'(bus.RAIL_EN),    32'(e_rail));
      chk("m_ocp_en",     32'(bus.OCP_EN),     32'(e_en));
      chk("m_ocp_clear",  32'(bus.OCP_CLEAR),  32'(e_clr));
      chk("m_busy",       32'(bus.BUSY),       32'(e_busy));
      chk("m_pwr_good",   32'(bus.PWR_GOOD),   32'(e_pg));
      chk("m_fault",      32'(bus.FAULT),      32'(e_fault));
      chk("m_fault_rail", 32'(bus.FAULT_RAIL), 32'(m_frail));
`ifdef OCP_AUTO_RETRY_EN
      chk("m_retry_cnt",  32'(bus.RETRY_CNT),  32'(m_retry));
`else
      chk("m_retry_cnt",  32'(bus.RETRY_CNT),  32'd0);
`endif
    end
  end

  task automatic start_pulse();
    bus.START = 1'b1; tick(1); bus.START = 1'b0;
  endtask

  task automatic to_run();
    start_pulse(); tick(RUN_T);
  endtask

  task automatic clear_fault();
    bus.FAULT_CLEAR = 1'b1; tick(1); bus.FAULT_CLEAR = 1'b0;
  endtask

  initial begin
    bus.START = 1'b0; bus.STOP = 1'b0; bus.FAULT_CLEAR = 1'b0; bus.OCP_RESULT = '0;
    tick(2);
    chk("rst_rail_en",   32'(bus.RAIL_EN),   32'h0);
    chk("rst_ocp_clear", 32'(bus.OCP_CLEAR), 32'h1);
    chk("rst_busy",      32'(bus.BUSY),      32'h0);
    rst = 1'b0;
    tick(2);

    // STOP wins over START in IDLE
    bus.START = 1'b1; bus.STOP = 1'b1; tick(2);
    chk("stop_wins_busy", 32'(bus.BUSY), 32'h0);
    bus.START = 1'b0; bus.STOP = 1'b0; tick(1);

    // 1: power-up sequence
    start_pulse();
    chk("up_r0", 32'(bus.RAIL_EN), 32'h1);
    tick(4);  chk("up_r1", 32'(bus.RAIL_EN), 32'h3);
    tick(8);  chk("up_r3", 32'(bus.RAIL_EN), 32'hF);
    tick(11); chk("blank_pg", 32'(bus.PWR_GOOD), 32'h0);
    tick(1);  chk("run_ocp_en", 32'(bus.OCP_EN), 32'hF);
    chk("run_pg", 32'(bus.PWR_GOOD), 32'h1);

    // 2: trip on rail 2, START ignored in FAULT, FAULT_CLEAR
    bus.OCP_RESULT = 4'b0100; tick(1);
    chk("trip_rail_en", 32'(bus.RAIL_EN), 32'h0);
    chk("trip_fault", 32'(bus.FAULT), 32'h1);
    chk("trip_fault_rail", 32'(bus.FAULT_RAIL), 32'h2);
    bus.START = 1'b1; tick(3); bus.START = 1'b0;
    chk("fault_holds", 32'(bus.FAULT), 32'h1);
    clear_fault(); bus.OCP_RESULT = '0;
    chk("clear_busy", 32'(bus.BUSY), 32'h0);
    chk("clear_fault_rail", 32'(bus.FAULT_RAIL), 32'h0);
    tick(1);

    // 3: sequenced power-down from RUN
    to_run();
    bus.STOP = 1'b1; tick(1); bus.STOP = 1'b0;
    chk("dn_r2", 32'(bus.RAIL_EN), 32'h7);
    chk("dn_clr", 32'(bus.OCP_CLEAR), 32'h1);
    tick(4); chk("dn_r1", 32'(bus.RAIL_EN), 32'h3);
    tick(4); chk("dn_r0", 32'(bus.RAIL_EN), 32'h1);
    tick(4); chk("dn_off", 32'(bus.RAIL_EN), 32'h0);
    chk("dn_busy", 32'(bus.BUSY), 32'h0);
    tick(1);

    // STOP part-way through power-up
    start_pulse(); tick(8);
    chk("pu_r2", 32'(bus.RAIL_EN), 32'h7);
    bus.STOP = 1'b1; tick(1); bus.STOP = 1'b0;
    chk("pu_stop", 32'(bus.RAIL_EN), 32'h3);
    tick(8); chk("pu_stop_idle", 32'(bus.BUSY), 32'h0);
    tick(1);

    // 4: trip and STOP together -> FAULT, lowest rail 1
    to_run();
    bus.OCP_RESULT = 4'b0110; bus.STOP = 1'b1; tick(1); bus.STOP = 1'b0;
    chk("both_fault", 32'(bus.FAULT), 32'h1);
    chk("both_fault_rail", 32'(bus.FAULT_RAIL), 32'h1);
    chk("both_rail_en", 32'(bus.RAIL_EN), 32'h0);
    clear_fault(); bus.OCP_RESULT = '0; tick(1);

    // 5: asynchronous reset mid power-up
    start_pulse(); tick(4);
    chk("ar_pre", 32'(bus.RAIL_EN), 32'h3);
    #1 rst = 1'b1;
    #1 chk("ar_rail_en", 32'(bus.RAIL_EN), 32'h0);
    chk("ar_ocp_clear", 32'(bus.OCP_CLEAR), 32'h1);
    chk("ar_busy", 32'(bus.BUSY), 32'h0);
    #1 rst = 1'b0;
    tick(6);
    chk("ar_idle", 32'(bus.BUSY), 32'h0);

`ifdef OCP_AUTO_RETRY_EN
    // 6: stuck trip -> two retries, then latched
    bus.OCP_RESULT = 4'b0001;
    start_pulse();
    for (int i = 0; i < 400 && !(bus.FAULT && bus.RETRY_CNT == 3'd2); i++) tick(1);
    chk("retry_reached", {31'd0, bus.FAULT}, 32'h1);
    tick(30);
    chk("retry_latched", 32'(bus.RETRY_CNT), 32'h2);
    chk("retry_fault", 32'(bus.FAULT), 32'h1);
    clear_fault(); bus.OCP_RESULT = '0;
    chk("retry_clr_cnt", 32'(bus.RETRY_CNT), 32'h0);
    tick(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
